seg7_scan_mux: RTL and testbench

Parametrised time-multiplexed driver for a common-anode seven-segment display bank; it generalises the fixed four-anode rotation to N digits with hex decode, decimal points, per-digit blanking, a programmable refresh rate and a dead-time between digits to suppress ghosting. It sits between the user-logic value registers and the board pins (an/seg/dp) of the Nexys4DDR top level. Display data is snapshotted once per frame, so a multi-digit value never tears.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_scan_mux_if.sv | 29 ++
 rtl/seg7_hex_decoder.sv | 14 +
 rtl/seg7_scan_mux.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex segment table for the seven-segment scan driver.
package seg7_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StScan = 1'b1
    } scan_state_e;

    // Active-high gfedcba patterns, index 15 (F) down to index 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display data in, board pin drive out, for the seven-segment scan driver.
interface seg7_scan_mux_if #(
    parameter int unsigned N_DIGITS = 8
);
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                    en;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp_in;
    logic [N_DIGITS-1:0]     digit_en;
    logic [N_DIGITS-1:0]     an;
    logic [6:0]              seg;
    logic                    dp;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;

    // User logic side: supplies the digits, observes the pin drive.
    modport master (
        output en, value, dp_in, digit_en,
        input  an, seg, dp, digit_idx, frame_tick
    );

    // Driver side.
    modport slave (
        input  en, value, dp_in, digit_en,
        output an, seg, dp, digit_idx, frame_tick
    );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-high gfedcba pattern; pin polarity is applied by the caller.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Pure table lookup.
    always_comb begin
        pattern = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with per-frame snapshot,
// per-slot blanking dead-time and registered pin outputs.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 8,
    parameter int unsigned PRESCALE       = 100000,
    parameter int unsigned BLANK_CYCLES   = 1000,
    parameter bit          ACTIVE_LOW_AN  = 1'b1,
    parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
    input logic             clk,
    input logic             rst,
    seg7_scan_mux_if.slave  bus
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(PRESCALE);

    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = ACTIVE_LOW_AN ? {N_DIGITS{1'b1}} : '0;
    localparam logic [6:0]          SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic                DP_OFF   = ACTIVE_LOW_SEG;

    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  snap_take;

    logic [4*N_DIGITS-1:0] snap_val_q;
    logic [N_DIGITS-1:0]   snap_dp_q;
    logic [N_DIGITS-1:0]   snap_en_q;

    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  scanning;
    logic                  in_blank;
    logic                  show;
    logic [4*N_DIGITS-1:0] val_sh;
    logic [N_DIGITS-1:0]   dp_sh;
    logic [N_DIGITS-1:0]   en_sh;
    logic [3:0]            nibble;
    logic [6:0]            seg_hi;
    logic [N_DIGITS-1:0]   an_hi;

    assign slot_end  = (cnt_q == LAST_CNT);
    assign frame_end = slot_end && (idx_q == LAST_IDX);
    // en is folded in so that a dropped enable darkens the pins on the very next edge.
    assign scanning  = (state_q == StScan) && bus.en;

    // With no dead-time the compare would be constant, so it is not built at all.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (32'(cnt_q) < BLANK_CYCLES);
    end

    // Shifts instead of variable bit-selects keep N_DIGITS=1 well formed.
    assign val_sh = snap_val_q >> {idx_q, 2'b00};
    assign dp_sh  = snap_dp_q >> idx_q;
    assign en_sh  = snap_en_q >> idx_q;
    assign nibble = val_sh[3:0];

    seg7_hex_decoder u_hex_decoder (
        .nibble  (nibble),
        .pattern (seg_hi)
    );

    // Next scan state, prescaler and digit index; snapshot on entry and at frame wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (bus.en) begin
                    state_d   = StScan;
                    snap_take = 1'b1;
                end
            end
            StScan: begin
                if (!bus.en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (slot_end) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d     = '0;
                        snap_take = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Pin values for the next edge, derived from the current slot and snapshot.
    always_comb begin
        show         = scanning && !in_blank && en_sh[0];
        an_hi        = show ? (N_DIGITS'(1) << idx_q) : '0;
        an_d         = ACTIVE_LOW_AN ? ~an_hi : an_hi;
        seg_d        = show ? seg_hi : 7'h00;
        seg_d        = ACTIVE_LOW_SEG ? ~seg_d : seg_d;
        dp_d         = show && dp_sh[0];
        dp_d         = ACTIVE_LOW_SEG ? ~dp_d : dp_d;
        digit_idx_d  = scanning ? idx_q : '0;
        frame_tick_d = scanning && frame_end;
    end

    // Scan FSM, counters and frame snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            snap_en_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (snap_take) begin
                snap_val_q <= bus.value;
                snap_dp_q  <= bus.dp_in;
                snap_en_q  <= bus.digit_en;
            end
        end
    end

    // Registered pin drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            digit_idx_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_idx_q  <= digit_idx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.digit_idx  = digit_idx_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: a 4-digit instance checked every cycle against a
// time-since-enable reference model through a scoreboard queue, plus a
// 1-digit zero-blank instance checked directly.
module tb_seg7_scan_mux;

    localparam int N = 4;
    localparam int P = 4;
    localparam int B = 1;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    exp_t        sb_q[$];
    bit          m_run;
    int          m_t;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_den;

    always #5 clk = ~clk;

    seg7_scan_mux_if #(.N_DIGITS(N)) bus_a ();
    seg7_scan_mux_if #(.N_DIGITS(1)) bus_b ();

    seg7_scan_mux #(
        .N_DIGITS       (N),
        .PRESCALE       (P),
        .BLANK_CYCLES   (B),
        .ACTIVE_LOW_AN  (1'b1),
        .ACTIVE_LOW_SEG (1'b1)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    seg7_scan_mux #(
        .N_DIGITS       (1),
        .PRESCALE       (2),
        .BLANK_CYCLES   (0),
        .ACTIVE_LOW_AN  (1'b1),
        .ACTIVE_LOW_SEG (1'b1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Active-low gfedcba for each hex digit.
    function automatic logic [6:0] hex_al(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Predict the 4-digit outputs for the coming edge, advance the model,
    // clock once, then compare against the oldest prediction.
    task automatic step();
        exp_t e;
        int   slot;
        int   c;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.idx = 2'd0;
        e.ft  = 1'b0;
        if (!rst && m_run && bus_a.en) begin
            slot  = (m_t / P) % N;
            c     = m_t % P;
            e.idx = 2'(slot);
            e.ft  = (c == P - 1) && (slot == N - 1);
            if (c >= B && m_den[slot]) begin
                e.an  = ~(4'b0001 << slot);
                e.seg = hex_al(m_val[slot*4 +: 4]);
                e.dp  = ~m_dp[slot];
            end
        end
        sb_q.push_back(e);
        if (rst) begin
            m_run = 1'b0;
            m_t   = 0;
        end else if (!m_run) begin
            if (bus_a.en) begin
                m_run = 1'b1;
                m_t   = 0;
                m_val = bus_a.value;
                m_dp  = bus_a.dp_in;
                m_den = bus_a.digit_en;
            end
        end else if (!bus_a.en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else begin
            m_t++;
            if (m_t % (N * P) == 0) begin
                m_val = bus_a.value;
                m_dp  = bus_a.dp_in;
                m_den = bus_a.digit_en;
            end
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("sb_an", bus_a.an, e.an);
        check_eq("sb_seg", bus_a.seg, e.seg);
        check_eq("sb_dp", bus_a.dp, e.dp);
        check_eq("sb_idx", bus_a.digit_idx, e.idx);
        check_eq("sb_ft", bus_a.frame_tick, e.ft);
    endtask

    initial begin
        logic [3:0] seen;
        int         dpcnt;
        int         ftcnt;
        int         ftfirst;

        rst               = 1'b1;
        bus_a.en          = 1'b0;
        bus_a.value       = '0;
        bus_a.dp_in       = '0;
        bus_a.digit_en    = '0;
        bus_b.en          = 1'b0;
        bus_b.value       = 4'h5;
        bus_b.dp_in       = 1'b1;
        bus_b.digit_en    = 1'b1;
        m_run             = 1'b0;
        m_t               = 0;
        m_val             = '0;
        m_dp              = '0;
        m_den             = '0;

        step();
        step();
        check_eq("rst_an", bus_a.an, 4'hF);
        check_eq("rst_seg", bus_a.seg, 7'h7F);
        check_eq("rst_b_an", bus_b.an, 1'b1);
        rst = 1'b0;
        step();

        // Rotation, digit-0 pattern and frame tick cadence.
        bus_a.value    = 16'h3210;
        bus_a.digit_en = 4'hF;
        bus_a.en       = 1'b1;
        step();
        check_eq("enter_an", bus_a.an, 4'hF);
        ftcnt   = 0;
        ftfirst = 0;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (bus_a.frame_tick) begin
                ftcnt++;
                if (ftfirst == 0) ftfirst = j;
            end
            if (j == 1) check_eq("d0_blank_an", bus_a.an, 4'hF);
            if (j == 2) begin
                check_eq("d0_an", bus_a.an, 4'hE);
                check_eq("d0_seg", bus_a.seg, 7'h40);
            end
            if (j == 5) check_eq("d1_blank_an", bus_a.an, 4'hF);
            if (j == 6) check_eq("d1_an", bus_a.an, 4'hD);
            if (j == 14) check_eq("d3_seg", bus_a.seg, 7'h30);
        end
        check_eq("ft_count", ftcnt, 2);
        check_eq("ft_first", ftfirst, 16);
        bus_a.en = 1'b0;
        step();

        // Mid-frame value change waits for the frame boundary.
        bus_a.value = 16'hF8A0;
        bus_a.en    = 1'b1;
        step();
        for (int j = 1; j <= 20; j++) begin
            step();
            if (j == 6) begin
                check_eq("old_d1_seg", bus_a.seg, 7'h08);
                bus_a.value = 16'h1111;
            end
            if (j == 10) check_eq("old_d2_seg", bus_a.seg, 7'h00);
            if (j == 14) check_eq("old_d3_seg", bus_a.seg, 7'h0E);
            if (j == 18) check_eq("new_d0_seg", bus_a.seg, 7'h79);
        end
        bus_a.en = 1'b0;
        step();

        // Blanked digits and decimal point.
        bus_a.value    = 16'h3210;
        bus_a.digit_en = 4'b0101;
        bus_a.dp_in    = 4'b0001;
        bus_a.en       = 1'b1;
        step();
        seen  = '0;
        dpcnt = 0;
        for (int j = 1; j <= 32; j++) begin
            step();
            seen = seen | ~bus_a.an;
            if (bus_a.dp == 1'b0) dpcnt++;
        end
        check_eq("an_seen", seen, 4'b0101);
        check_eq("dp_count", dpcnt, 6);

        // Enable dropped during digit 2, then restart at digit 0.
        bus_a.en = 1'b0;
        step();
        bus_a.digit_en = 4'hF;
        bus_a.dp_in    = 4'h0;
        bus_a.en       = 1'b1;
        step();
        for (int j = 1; j <= 10; j++) step();
        check_eq("d2_active_an", bus_a.an, 4'hB);
        bus_a.en = 1'b0;
        step();
        check_eq("drop_an", bus_a.an, 4'hF);
        check_eq("drop_seg", bus_a.seg, 7'h7F);
        check_eq("drop_idx", bus_a.digit_idx, 2'd0);
        bus_a.en = 1'b1;
        step();
        step();
        check_eq("restart_blank", bus_a.an, 4'hF);
        step();
        check_eq("restart_d0_an", bus_a.an, 4'hE);

        // Asynchronous reset between edges.
        for (int j = 0; j < 5; j++) step();
        rst = 1'b1;
        #1;
        check_eq("arst_an", bus_a.an, 4'hF);
        check_eq("arst_seg", bus_a.seg, 7'h7F);
        check_eq("arst_dp", bus_a.dp, 1'b1);
        check_eq("arst_ft", bus_a.frame_tick, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check_eq("post_rst_an", bus_a.an, 4'hE);
        bus_a.en = 1'b0;
        step();

        // Single digit, no dead-time, two-clock slot.
        bus_b.en = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
            check_eq("b_an", bus_b.an, 1'b0);
            check_eq("b_seg", bus_b.seg, 7'h12);
            check_eq("b_dp", bus_b.dp, 1'b0);
            check_eq("b_ft", bus_b.frame_tick, (i % 2 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
